// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU (alu_seq) and its
// iterative multiplier. Build option: define ALU_SEQ_EARLY_TERM_EN to let
// MUL finish as soon as the remaining multiplier bits are all zero.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_EOR = 3'b100,
    OP_ADC = 3'b101,
    OP_SBC = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MUL_BUSY = 2'b01,
    DONE     = 2'b10
  } alu_state_t;

  // Bit positions inside a {N,Z,C,V} nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: one multiplier bit per cycle, low WIDTH bits of the
// unsigned product. With ALU_SEQ_EARLY_TERM_EN defined it stops once the
// remaining multiplier bits are zero; otherwise it always runs STEPS steps.
// 'done' and 'product' are combinational during the final step so the
// caller can capture the finished product on the same edge.
import alu_pkg::*;

module alu_mul_iter #(
  parameter int WIDTH = 32,
  parameter int STEPS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(STEPS + 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    count;

  // Partial product after the step currently in progress; also the final
  // product on the cycle 'done' is high.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  assign product = acc_next;

`ifdef ALU_SEQ_EARLY_TERM_EN
  // Finish once this step consumes the last set multiplier bit.
  assign done = busy && (mplier[WIDTH-1:1] == '0);
`else
  // Finish on the last of the fixed number of steps.
  assign done = busy && (count == CW'(STEPS - 1));
`endif

  // Step register: load on start, then shift multiplicand left and
  // multiplier right once per cycle until done; reset aborts a run.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      acc    <= '0;
      mcand  <= A;
      mplier <= B;
      count  <= '0;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with an NZCV flags register and an iterative
// MUL that stalls issue through in_ready. Build option:
// ALU_SEQ_EARLY_TERM_EN shortens MUL latency (forwarded to alu_mul_iter).
import alu_pkg::*;

module alu_seq #(
  parameter int WIDTH     = 32,
  parameter int MUL_STEPS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUControl,
  input  logic             SetFlags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ResultFlags,
  output logic [3:0]       ALUFlags
);

  alu_state_t state, next_state;
  alu_op_t    op_in;

  logic             accept;
  logic             commit;
  logic             set_flags_q;
  logic [1:0]       cv_q;
  logic [3:0]       flags_eff;
  logic [WIDTH-1:0] opb;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign op_in     = alu_op_t'(ALUControl);
  assign accept    = in_valid & in_ready;
  assign commit    = out_valid & out_ready & set_flags_q;
  assign mul_start = accept && (op_in == OP_MUL);

  // Flags seen by an op accepted this edge: if the previous result commits
  // its flags on the same edge, bypass them so ADC/SBC chain correctly.
  assign flags_eff = commit ? ResultFlags : ALUFlags;

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .STEPS (MUL_STEPS)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .A       (A),
    .B       (B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath for everything except MUL, computed at WIDTH+1
  // bits so the carry-out lands in the top bit.
  always_comb begin
    opb       = B;
    cin       = 1'b0;
    alu_res   = '0;
    alu_flags = '0;
    case (op_in)
      OP_SUB: begin
        opb = ~B;
        cin = 1'b1;
      end
      OP_ADC: begin
        cin = flags_eff[FLAG_C];
      end
      OP_SBC: begin
        opb = ~B;
        cin = flags_eff[FLAG_C];
      end
      default: begin
        opb = B;
        cin = 1'b0;
      end
    endcase
    sum = {1'b0, A} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
    case (op_in)
      OP_AND:  alu_res = A & B;
      OP_ORR:  alu_res = A | B;
      OP_EOR:  alu_res = A ^ B;
      default: alu_res = sum[WIDTH-1:0];
    endcase
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
    if ((op_in != OP_AND) && (op_in != OP_ORR) && (op_in != OP_EOR)) begin
      alu_flags[FLAG_C] = sum[WIDTH];
      alu_flags[FLAG_V] = (A[WIDTH-1] == opb[WIDTH-1]) &&
                          (sum[WIDTH-1] != A[WIDTH-1]);
    end
  end

  // Handshake FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and handshake outputs; DONE lets a new op in as the
  // current result drains.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = (op_in == OP_MUL) ? MUL_BUSY : DONE;
        end
      end
      MUL_BUSY: begin
        if (mul_busy && mul_done) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            next_state = (op_in == OP_MUL) ? MUL_BUSY : DONE;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Result, result flags and architectural flags: capture on accept (or on
  // MUL completion), commit NZCV when a flag-setting result drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUResult   <= '0;
      ResultFlags <= '0;
      ALUFlags    <= '0;
      set_flags_q <= 1'b0;
      cv_q        <= '0;
    end else begin
      if (commit) begin
        ALUFlags <= ResultFlags;
      end
      if (accept) begin
        set_flags_q <= SetFlags;
        if (op_in == OP_MUL) begin
          cv_q <= {flags_eff[FLAG_C], flags_eff[FLAG_V]};
        end else begin
          ALUResult   <= alu_res;
          ResultFlags <= alu_flags;
        end
      end else if ((state == MUL_BUSY) && mul_done) begin
        ALUResult   <= mul_product;
        ResultFlags <= {mul_product[WIDTH-1], (mul_product == '0), cv_q};
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a 32-bit and an 8-bit instance, directed
// vectors with hand-computed results, scoreboard queues popped by monitors
// whenever a result is handed over.
import alu_pkg::*;

module tb_alu_seq;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, SetFlags, out_valid, out_ready;
  logic [31:0] A, B, ALUResult;
  logic [2:0]  ALUControl;
  logic [3:0]  ResultFlags, ALUFlags;

  logic        in_valid8, in_ready8, SetFlags8, out_valid8, out_ready8;
  logic [7:0]  A8, B8, ALUResult8;
  logic [2:0]  ALUControl8;
  logic [3:0]  ResultFlags8, ALUFlags8;

  exp_t exp_q[$];
  exp_t exp_q8[$];
  exp_t mon_e;
  exp_t mon_e8;

  int n_checks = 0;
  int n_pass   = 0;

  alu_seq #(.WIDTH(32), .MUL_STEPS(32)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUControl(ALUControl), .SetFlags(SetFlags),
    .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult),
    .ResultFlags(ResultFlags), .ALUFlags(ALUFlags)
  );

  alu_seq #(.WIDTH(8), .MUL_STEPS(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A8), .B(B8), .ALUControl(ALUControl8), .SetFlags(SetFlags8),
    .out_valid(out_valid8), .out_ready(out_ready8), .ALUResult(ALUResult8),
    .ResultFlags(ResultFlags8), .ALUFlags(ALUFlags8)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Overall time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issue one op on the 32-bit DUT, optionally queueing its expected result
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic sf,
                               input logic [31:0] er, input logic [3:0] ef,
                               input bit push);
    int waited;
    exp_t e;
    waited = 0;
    ALUControl = op;
    A = a;
    B = b;
    SetFlags = sf;
    in_valid = 1'b1;
    if (push) begin
      e.res = er;
      e.flags = ef;
      exp_q.push_back(e);
    end
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      $display("[TB] FAIL accept_timeout: in_ready got 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Issue one op on the 8-bit DUT
  task automatic applyStimulus8(input logic [2:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic sf,
                                input logic [7:0] er, input logic [3:0] ef);
    int waited;
    exp_t e;
    waited = 0;
    ALUControl8 = op;
    A8 = a;
    B8 = b;
    SetFlags8 = sf;
    in_valid8 = 1'b1;
    e.res = {24'd0, er};
    e.flags = ef;
    exp_q8.push_back(e);
    @(negedge clk);
    while (!in_ready8 && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready8) begin
      n_checks++;
      $display("[TB] FAIL accept8_timeout: in_ready got 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
  endtask

  // Wait until the 32-bit DUT is back in IDLE with nothing pending
  task automatic waitIdle();
    int waited;
    waited = 0;
    @(negedge clk);
    while ((out_valid || !in_ready) && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (out_valid || !in_ready) begin
      n_checks++;
      $display("[TB] FAIL idle_timeout: out_valid got %0b, expected 0", out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for the 32-bit DUT: compare each handed-over result
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_output: got 0x%0h, expected none", ALUResult);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("result32", {32'd0, ALUResult}, {32'd0, mon_e.res});
        checkOutput("rflags32", {60'd0, ResultFlags}, {60'd0, mon_e.flags});
      end
    end
  end

  // Scoreboard monitor for the 8-bit DUT
  always @(negedge clk) begin
    if (!reset && out_valid8 && out_ready8) begin
      if (exp_q8.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_output8: got 0x%0h, expected none", ALUResult8);
      end else begin
        mon_e8 = exp_q8.pop_front();
        checkOutput("result8", {56'd0, ALUResult8}, {32'd0, mon_e8.res});
        checkOutput("rflags8", {60'd0, ResultFlags8}, {60'd0, mon_e8.flags});
      end
    end
  end

  // Directed stimulus
  initial begin
    int cycles;
    int busy;
    int exp_cycles;
    int exp_busy;
`ifdef ALU_SEQ_EARLY_TERM_EN
    exp_cycles = 18;
    exp_busy   = 17;
`else
    exp_cycles = 33;
    exp_busy   = 32;
`endif
    reset = 1'b1;
    in_valid = 1'b0;  out_ready = 1'b1;  A = '0;  B = '0;  ALUControl = '0;  SetFlags = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; A8 = '0; B8 = '0; ALUControl8 = '0; SetFlags8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_result", {32'd0, ALUResult}, 64'd0);
    checkOutput("rst_rflags", {60'd0, ResultFlags}, 64'd0);
    checkOutput("rst_aluflags", {60'd0, ALUFlags}, 64'd0);
    checkOutput("rst_aluflags8", {60'd0, ALUFlags8}, 64'd0);
    @(posedge clk);
    #1;

    // ADD overflow, one-cycle latency, flag commit
    applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 4'b1001, 1'b1);
    @(negedge clk);
    checkOutput("add_latency", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    #1;
    checkOutput("add_commit", {60'd0, ALUFlags}, 64'b1001);

    // SUB then back-to-back SBC using the bypassed carry, then logic/ADC/ADD stream
    applyStimulus(OP_SUB, 32'd5, 32'd5, 1'b1, 32'd0, 4'b0110, 1'b1);
    applyStimulus(OP_SBC, 32'd0, 32'd0, 1'b1, 32'd0, 4'b0110, 1'b1);
    applyStimulus(OP_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 32'd0, 4'b0100, 1'b1);
    applyStimulus(OP_ORR, 32'h8000_0000, 32'h1, 1'b0, 32'h8000_0001, 4'b1000, 1'b1);
    applyStimulus(OP_ADC, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'd0, 4'b0110, 1'b1);
    applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 4'b1001, 1'b1);
    waitIdle();
    checkOutput("stream_commit", {60'd0, ALUFlags}, 64'b1001);

    // MUL with zero low product: Z set, C/V carried over, latency measured
    applyStimulus(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'd0, 4'b0101, 1'b1);
    cycles = 0;
    busy = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (!in_ready) busy++;
    end while (!out_valid && cycles < 200);
    checkOutput("mul_latency", 64'(cycles), 64'(exp_cycles));
    checkOutput("mul_stall", 64'(busy), 64'(exp_busy));
    @(posedge clk);
    #1;
    applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 4'b0001, 1'b1);
    waitIdle();
    checkOutput("mul_commit", {60'd0, ALUFlags}, 64'b0101);

    // EOR held by out_ready low: stable output, stalled issue, no commit
    out_ready = 1'b0;
    applyStimulus(OP_EOR, 32'h0000_F0F0, 32'h0000_FFFF, 1'b1, 32'h0000_0F0F, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("hold_result", {32'd0, ALUResult}, 64'h0F0F);
      checkOutput("hold_in_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("hold_no_commit", {60'd0, ALUFlags}, 64'b0101);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitIdle();
    checkOutput("eor_commit", {60'd0, ALUFlags}, 64'b0000);

    // Borrowing SUB, then reset in the middle of a MUL
    applyStimulus(OP_SUB, 32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF, 4'b1000, 1'b1);
    waitIdle();
    checkOutput("sub_commit", {60'd0, ALUFlags}, 64'b1000);
    applyStimulus(OP_MUL, 32'd3, 32'h8000_0000, 1'b1, 32'd0, 4'b0000, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("abort_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("abort_aluflags", {60'd0, ALUFlags}, 64'd0);
    checkOutput("abort_result", {32'd0, ALUResult}, 64'd0);
    @(posedge clk);
    #1;

    // Normal operation resumes after the abort
    applyStimulus(OP_ADD, 32'd2, 32'd3, 1'b0, 32'd5, 4'b0000, 1'b1);
    applyStimulus(OP_MUL, 32'd3, 32'd5, 1'b1, 32'd15, 4'b0000, 1'b1);
    applyStimulus(OP_MUL, 32'd7, 32'h8000_0000, 1'b0, 32'h8000_0000, 4'b1000, 1'b1);
    waitIdle();

    // 8-bit instance: carry chain, signed overflow and MUL
    applyStimulus8(OP_ADD, 8'hFF, 8'h01, 1'b1, 8'h00, 4'b0110);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("w8_add_commit", {60'd0, ALUFlags8}, 64'b0110);
    applyStimulus8(OP_ADC, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b0110);
    applyStimulus8(OP_SBC, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b0011);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus8(OP_MUL, 8'h0F, 8'h11, 1'b0, 8'hFF, 4'b1011);

    repeat (40) @(posedge clk);
    #1;
    checkOutput("w8_final_flags", {60'd0, ALUFlags8}, 64'b0011);
    checkOutput("queue32_empty", 64'(exp_q.size()), 64'd0);
    checkOutput("queue8_empty", 64'(exp_q8.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
